instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 20 ++
 rtl/instruction_fetch_pc_register.sv | 24 ++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, datapath
// width, reset fetch address and instruction field positions.
package instruction_fetch_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam logic [15:0] RESET_PC   = 16'h0000;

  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 12;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_HALT
  } state_t;

endpackage

// File: rtl/instruction_fetch_pc_register.sv
// Loadable address register with synchronous reset and a wrapping +1 output.
module pc_register #(
  parameter int unsigned       WIDTH       = 16,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_plus1
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VALUE;
    end else if (load) begin
      q <= d;
    end
  end

  assign q_plus1 = q + WIDTH'(1);

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: requests one word at fetch_pc, holds it for the
// decoder until retired, then follows sequential, redirect or halt flow.
module instruction_fetch #(
  parameter int unsigned            WORD_WIDTH = instruction_fetch_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0]  RESET_PC   = instruction_fetch_pkg::RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  i_readM,
  output logic [WORD_WIDTH-1:0] i_address,
  input  logic [WORD_WIDTH-1:0] i_data,
  input  logic                  i_ready,
  output logic [WORD_WIDTH-1:0] instr,
  output logic [3:0]            opcode,
  output logic [5:0]            func,
  output logic                  instr_valid,
  output logic [WORD_WIDTH-1:0] pc,
  output logic [WORD_WIDTH-1:0] pc_next,
  input  logic                  advance,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] target,
  input  logic                  halt,
  output logic                  halted,
  output logic [WORD_WIDTH-1:0] num_inst
);

  import instruction_fetch_pkg::*;

  state_t                state;
  logic [WORD_WIDTH-1:0] fetch_pc;
  logic                  capture;

  assign capture = (state == S_FETCH) && i_ready;

  // The held pc only changes on a capture, so pc/pc_next stay stable in S_HOLD.
  pc_register #(
    .WIDTH       (WORD_WIDTH),
    .RESET_VALUE ('0)
  ) u_pc (
    .clk     (clk),
    .reset   (reset),
    .load    (capture),
    .d       (fetch_pc),
    .q       (pc),
    .q_plus1 (pc_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_PC;
      instr    <= '0;
      num_inst <= '0;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (i_ready) begin
            instr <= i_data;
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (advance) begin
            num_inst <= num_inst + WORD_WIDTH'(1);
            // halt takes priority; the redirect target is dropped with it
            if (halt) begin
              state <= S_HALT;
            end else begin
              fetch_pc <= redirect ? target : pc_next;
              state    <= S_FETCH;
            end
          end
        end
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i_readM     = (state == S_FETCH);
  assign instr_valid = (state == S_HOLD);
  assign halted      = (state == S_HALT);
  assign i_address   = fetch_pc;
  assign opcode      = instr[OPCODE_MSB:OPCODE_LSB];
  assign func        = instr[FUNC_MSB:FUNC_LSB];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: randomized memory latency and
// retire decisions checked against a transaction-level fetch model.
module tb_instruction_fetch;

  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int unsigned N_TXN    = 60;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_ready = 1'b0;
  logic [15:0] i_data = '0;
  logic        advance = 1'b0;
  logic        redirect = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] target = '0;

  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [5:0]  func;
  logic        instr_valid;
  logic [15:0] pc;
  logic [15:0] pc_next;
  logic        halted;
  logic [15:0] num_inst;

  instruction_fetch #(
    .WORD_WIDTH (16),
    .RESET_PC   (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .instr       (instr),
    .opcode      (opcode),
    .func        (func),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_next     (pc_next),
    .advance     (advance),
    .redirect    (redirect),
    .target      (target),
    .halt        (halt),
    .halted      (halted),
    .num_inst    (num_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] cnt;
  } hold_t;

  hold_t       hold_q[$];
  logic [15:0] addr_q[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // reference model state
  logic [15:0] fpc;
  logic [15:0] cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each new fetch request and each newly held instruction is
  // compared with the next entry the stimulus side predicted.
  logic prev_readM = 1'b0;
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    hold_t h;
    if (i_readM && !prev_readM) begin
      if (addr_q.size() == 0) chk("unexpected_fetch", 1, 0);
      else chk("i_address", i_address, addr_q.pop_front());
    end
    if (instr_valid && !prev_valid) begin
      if (hold_q.size() == 0) chk("unexpected_valid", 1, 0);
      else begin
        h = hold_q.pop_front();
        chk("instr",    instr,    h.data);
        chk("opcode",   opcode,   h.data[15:12]);
        chk("func",     func,     h.data[5:0]);
        chk("pc",       pc,       h.pc);
        chk("pc_next",  pc_next,  h.pc_next);
        chk("num_inst", num_inst, h.cnt);
      end
    end
    prev_readM = i_readM;
    prev_valid = instr_valid;
  end

  task automatic model_reset();
    fpc = RESET_PC;
    cnt = '0;
    addr_q.delete();
    hold_q.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    i_ready = 1'b0; advance = 1'b0; redirect = 1'b0; halt = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_instr",     instr,       0);
    chk("rst_pc",        pc,          0);
    chk("rst_num_inst",  num_inst,    0);
    chk("rst_readM",     i_readM,     0);
    chk("rst_valid",     instr_valid, 0);
    chk("rst_halted",    halted,      0);
    chk("rst_i_address", i_address,   RESET_PC);
    model_reset();
    addr_q.push_back(RESET_PC);
    reset = 1'b0;
  endtask

  task automatic wait_fetch();
    for (int i = 0; i < 20; i++) begin
      if (i_readM) return;
      @(negedge clk);
    end
    $display("FAIL fetch_timeout actual=i_readM low required=i_readM high");
    $fatal(1, "fetch request never appeared");
  endtask

  initial begin
    int unsigned lat, hold_cycles;
    logic [15:0] word, tgt;
    logic        do_redir, do_halt;

    do_reset();
    for (int t = 0; t < int'(N_TXN); t++) begin
      wait_fetch();

      lat = (t == 0) ? 1 : $urandom_range(0, 3);
      for (int unsigned k = 0; k < lat; k++) begin
        i_ready  = 1'b0;
        advance  = 1'($urandom_range(0, 1));
        redirect = 1'($urandom_range(0, 1));
        halt     = 1'($urandom_range(0, 1));
        target   = 16'($urandom);
        @(negedge clk);
        chk("stall_readM",    i_readM,     1);
        chk("stall_address",  i_address,   fpc);
        chk("stall_num_inst", num_inst,    cnt);
        chk("stall_valid",    instr_valid, 0);
      end
      advance = 1'b0; redirect = 1'b0; halt = 1'b0;

      if (t > 3 && $urandom_range(0, 9) == 0) begin
        reset = 1'b1;
        @(negedge clk);
        i_ready = 1'b1;
        i_data  = 16'($urandom);
        @(negedge clk);
        i_ready = 1'b0;
        @(negedge clk);
        chk("midrst_instr",   instr,     0);
        chk("midrst_readM",   i_readM,   0);
        chk("midrst_address", i_address, RESET_PC);
        chk("midrst_count",   num_inst,  0);
        model_reset();
        addr_q.push_back(RESET_PC);
        reset = 1'b0;
        continue;
      end

      word = (t == 0) ? 16'hF01C : 16'($urandom);
      i_data  = word;
      i_ready = 1'b1;
      hold_q.push_back('{data: word, pc: fpc, pc_next: 16'((32'(fpc) + 1) % 65536), cnt: cnt});
      @(negedge clk);
      i_ready = 1'b0;
      i_data  = 16'($urandom);
      chk("valid_latency", instr_valid, 1);

      hold_cycles = $urandom_range(0, 3);
      for (int unsigned k = 0; k < hold_cycles; k++) begin
        i_ready = 1'($urandom_range(0, 1));
        i_data  = 16'($urandom);
        @(negedge clk);
        chk("hold_instr", instr,       word);
        chk("hold_valid", instr_valid, 1);
        chk("hold_readM", i_readM,     0);
      end
      i_ready = 1'b0;

      case (t)
        0: begin do_redir = 1'b1; do_halt = 1'b0; tgt = 16'h0040; end
        1: begin do_redir = 1'b1; do_halt = 1'b0; tgt = 16'hFFFF; end
        2: begin do_redir = 1'b0; do_halt = 1'b0; tgt = 16'h1234; end
        default: begin
          do_redir = 1'($urandom_range(0, 1));
          do_halt  = ($urandom_range(0, 11) == 0);
          tgt      = 16'($urandom);
        end
      endcase

      cnt = 16'((32'(cnt) + 1) % 65536);
      if (!do_halt) begin
        fpc = do_redir ? tgt : 16'((32'(fpc) + 1) % 65536);
        addr_q.push_back(fpc);
      end
      advance = 1'b1; redirect = do_redir; halt = do_halt; target = tgt;
      @(negedge clk);
      advance = 1'b0; redirect = 1'b0; halt = 1'b0;
      chk("retire_num_inst", num_inst, cnt);

      if (do_halt) begin
        chk("halt_halted", halted,      1);
        chk("halt_readM",  i_readM,     0);
        chk("halt_valid",  instr_valid, 0);
        for (int k = 0; k < 4; k++) begin
          i_ready  = 1'b1;
          i_data   = 16'($urandom);
          advance  = 1'b1;
          redirect = 1'b1;
          halt     = 1'($urandom_range(0, 1));
          @(negedge clk);
          chk("halted_stays",   halted,   1);
          chk("halted_readM",   i_readM,  0);
          chk("halted_count",   num_inst, cnt);
        end
        do_reset();
      end
    end

    i_ready = 1'b0; advance = 1'b0;
    repeat (4) @(negedge clk);
    chk("addr_q_drained", addr_q.size(), 0);
    chk("hold_q_drained", hold_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
